// File: rtl/load_store_initiator_if.sv
// Bus bundle between the CPU, the load/store initiator and the data memory.
// The master modport is the initiator's view; the slave modport is the
// environment (CPU request side plus memory) that surrounds it.
interface load_store_initiator_if;
  // CPU request channel
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [1:0]  Req_Size;
  logic        Req_Unsigned;
  logic [31:0] Req_Addr;
  logic [31:0] Req_WData;

  // CPU response channel
  logic        Resp_Valid;
  logic        Resp_Ready;
  logic [31:0] Resp_RData;
  logic        Resp_Error;

  // Data-memory port
  logic [31:0] Mem_Address;
  logic [31:0] Mem_WriteData;
  logic        Mem_MemWrite;
  logic        Mem_MemRead;
  logic        Mem_HalfControl;
  logic        Mem_ByteControl;
  logic [31:0] Mem_ReadData;

  // Status
  logic [15:0] Txn_Count;

  modport master (
    input  Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Addr, Req_WData,
    output Req_Ready,
    output Resp_Valid, Resp_RData, Resp_Error,
    input  Resp_Ready,
    output Mem_Address, Mem_WriteData, Mem_MemWrite, Mem_MemRead,
    output Mem_HalfControl, Mem_ByteControl,
    input  Mem_ReadData,
    output Txn_Count
  );

  modport slave (
    output Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Addr, Req_WData,
    input  Req_Ready,
    input  Resp_Valid, Resp_RData, Resp_Error,
    output Resp_Ready,
    input  Mem_Address, Mem_WriteData, Mem_MemWrite, Mem_MemRead,
    input  Mem_HalfControl, Mem_ByteControl,
    output Mem_ReadData,
    input  Txn_Count
  );
endinterface

// File: rtl/load_store_initiator.sv
// Load/store initiator: takes one CPU access at a time, checks alignment and
// range, drives the data-memory strobes for LATENCY cycles and returns a
// single response (load data or error) that is held until the CPU takes it.
module load_store_initiator #(
  parameter int MEM_BYTES = 32768,
  parameter int LATENCY   = 1      // 1..15 cycles of memory strobes per access
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  load_store_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic        write_q,      write_d;
  logic [1:0]  size_q,       size_d;
  logic        unsigned_q,   unsigned_d;
  logic [31:0] mem_addr_q,   mem_addr_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic [15:0] txn_count_q,  txn_count_d;

  logic        req_error;
  logic        in_access;
  logic [31:0] load_data;

  // Classify the incoming request: illegal size, misalignment or out of range.
  always_comb begin
    req_error = 1'b0;
    if (bus.Req_Size == 2'b11) begin
      req_error = 1'b1;
    end
    if ((bus.Req_Size == SIZE_HALF) && bus.Req_Addr[0]) begin
      req_error = 1'b1;
    end
    if ((bus.Req_Size == SIZE_WORD) && (bus.Req_Addr[1:0] != 2'b00)) begin
      req_error = 1'b1;
    end
    if ({1'b0, bus.Req_Addr} >= MEM_LIMIT) begin
      req_error = 1'b1;
    end
  end

  // Load result: memory already sign-extends, so unsigned loads just clear
  // the bits above the access size.
  always_comb begin
    load_data = bus.Mem_ReadData;
    if (unsigned_q) begin
      case (size_q)
        SIZE_BYTE: load_data = {24'h00_0000, bus.Mem_ReadData[7:0]};
        SIZE_HALF: load_data = {16'h0000, bus.Mem_ReadData[15:0]};
        default:   load_data = bus.Mem_ReadData;
      endcase
    end
  end

  // Next-state and datapath update for the IDLE -> ACCESS -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    txn_count_d  = txn_count_q;

    case (state_q)
      IDLE: begin
        if (bus.Req_Valid) begin
          write_d    = bus.Req_Write;
          size_d     = bus.Req_Size;
          unsigned_d = bus.Req_Unsigned;
          if (req_error) begin
            // Rejected accesses never touch memory, so the memory-side
            // address/data registers keep the last legal access.
            state_d      = RESP;
            resp_rdata_d = 32'h0000_0000;
            resp_error_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = CNT_INIT;
            mem_addr_d  = bus.Req_Addr;
            mem_wdata_d = bus.Req_WData;
          end
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = RESP;
          resp_error_d = 1'b0;
          resp_rdata_d = write_q ? 32'h0000_0000 : load_data;
        end
      end

      RESP: begin
        if (bus.Resp_Ready) begin
          state_d     = IDLE;
          txn_count_d = txn_count_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      resp_rdata_q <= 32'h0000_0000;
      resp_error_q <= 1'b0;
      txn_count_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      txn_count_q  <= txn_count_d;
    end
  end

  // Strobes decode straight from registered state, so an asynchronous reset
  // drops them immediately. The write strobe only fires on the last ACCESS
  // cycle, giving exactly one memory write per store.
  assign in_access           = (state_q == ACCESS);
  assign bus.Mem_MemRead     = in_access && !write_q;
  assign bus.Mem_MemWrite    = in_access && write_q && (cnt_q == 4'd0);
  assign bus.Mem_HalfControl = in_access && (size_q == SIZE_HALF);
  assign bus.Mem_ByteControl = in_access && (size_q == SIZE_BYTE);
  assign bus.Mem_Address     = mem_addr_q;
  assign bus.Mem_WriteData   = mem_wdata_q;

  assign bus.Req_Ready  = (state_q == IDLE);
  assign bus.Resp_Valid = (state_q == RESP);
  assign bus.Resp_RData = resp_rdata_q;
  assign bus.Resp_Error = resp_error_q;
  assign bus.Txn_Count  = txn_count_q;

endmodule

// File: tb/tb_load_store_initiator.sv
// Directed bench for load_store_initiator: one instance with LATENCY=1 and one
// with LATENCY=3 share a request driver; sel routes the handshake to one of them.
module tb_load_store_initiator;

  logic clk = 1'b0;
  logic rst1_n = 1'b1;
  logic rst3_n = 1'b1;
  always #5 clk = ~clk;

  load_store_initiator_if ifc1 ();
  load_store_initiator_if ifc3 ();

  load_store_initiator #(.MEM_BYTES(32768), .LATENCY(1)) dut1 (
    .Clk(clk), .Reset_n(rst1_n), .bus(ifc1.master));
  load_store_initiator #(.MEM_BYTES(32768), .LATENCY(3)) dut3 (
    .Clk(clk), .Reset_n(rst3_n), .bus(ifc3.master));

  // shared drivers
  logic        sel = 1'b0;
  logic        drv_valid = 1'b0, drv_write = 1'b0, drv_uns = 1'b0, drv_resp_ready = 1'b0;
  logic [1:0]  drv_size = 2'b00;
  logic [31:0] drv_addr = 32'h0, drv_wdata = 32'h0, drv_rdata = 32'h0;

  assign ifc1.Req_Valid    = drv_valid & ~sel;
  assign ifc3.Req_Valid    = drv_valid & sel;
  assign ifc1.Resp_Ready   = drv_resp_ready & ~sel;
  assign ifc3.Resp_Ready   = drv_resp_ready & sel;
  assign ifc1.Req_Write    = drv_write;
  assign ifc3.Req_Write    = drv_write;
  assign ifc1.Req_Size     = drv_size;
  assign ifc3.Req_Size     = drv_size;
  assign ifc1.Req_Unsigned = drv_uns;
  assign ifc3.Req_Unsigned = drv_uns;
  assign ifc1.Req_Addr     = drv_addr;
  assign ifc3.Req_Addr     = drv_addr;
  assign ifc1.Req_WData    = drv_wdata;
  assign ifc3.Req_WData    = drv_wdata;
  assign ifc1.Mem_ReadData = drv_rdata;
  assign ifc3.Mem_ReadData = drv_rdata;

  // observed outputs of the selected instance
  wire        obs_req_ready  = sel ? ifc3.Req_Ready  : ifc1.Req_Ready;
  wire        obs_resp_valid = sel ? ifc3.Resp_Valid : ifc1.Resp_Valid;
  wire [31:0] obs_resp_rdata = sel ? ifc3.Resp_RData : ifc1.Resp_RData;
  wire        obs_resp_error = sel ? ifc3.Resp_Error : ifc1.Resp_Error;
  wire [31:0] obs_mem_addr   = sel ? ifc3.Mem_Address : ifc1.Mem_Address;
  wire [31:0] obs_mem_wdata  = sel ? ifc3.Mem_WriteData : ifc1.Mem_WriteData;
  wire        obs_rd         = sel ? ifc3.Mem_MemRead : ifc1.Mem_MemRead;
  wire        obs_wr         = sel ? ifc3.Mem_MemWrite : ifc1.Mem_MemWrite;
  wire        obs_half       = sel ? ifc3.Mem_HalfControl : ifc1.Mem_HalfControl;
  wire        obs_byte       = sel ? ifc3.Mem_ByteControl : ifc1.Mem_ByteControl;
  wire [3:0]  obs_strobes    = {obs_rd, obs_wr, obs_half, obs_byte};
  wire [15:0] obs_txn        = sel ? ifc3.Txn_Count : ifc1.Txn_Count;

  // write-strobe monitor for the LATENCY=3 instance
  int wr3_count = 0;
  always @(posedge clk) if (ifc3.Mem_MemWrite === 1'b1) wr3_count <= wr3_count + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_txn1 = 16'h0, exp_txn3 = 16'h0;

  // results captured by run_txn
  logic        r_accepted, r_err, r_rd_half, r_rd_byte, r_wr_half, r_wr_byte;
  logic        r_stable, r_ready_low, r_after_valid, r_after_ready;
  logic [3:0]  r_strobe_resp;
  logic [31:0] r_rdata, r_rd_addr, r_wr_addr, r_wr_data, r_mem_addr_resp;
  logic [15:0] r_txn_after;
  int          r_latency, r_reads, r_writes, r_wr_cycle;

  // Drive one request to the selected instance, measure strobes and latency,
  // hold the response for 'hold' cycles, then complete the handshake.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int  cyc;
    logic timed_out;
    r_reads = 0; r_writes = 0; r_wr_cycle = 0; r_rd_addr = 32'h0;
    r_rd_half = 0; r_rd_byte = 0; r_wr_half = 0; r_wr_byte = 0;
    r_wr_addr = 32'h0; r_wr_data = 32'h0; timed_out = 1'b0;
    @(negedge clk);
    drv_write = w; drv_size = sz; drv_uns = uns; drv_addr = addr; drv_wdata = wdata;
    drv_valid = 1'b1;
    r_accepted = obs_req_ready;
    @(posedge clk);
    r_latency = 1;
    cyc = 0;
    forever begin
      @(negedge clk);
      drv_valid = 1'b0;
      if (obs_resp_valid === 1'b1) break;
      cyc++;
      if (obs_rd === 1'b1) begin
        r_reads++; r_rd_addr = obs_mem_addr; r_rd_half = obs_half; r_rd_byte = obs_byte;
      end
      if (obs_wr === 1'b1) begin
        r_writes++; r_wr_cycle = cyc; r_wr_addr = obs_mem_addr; r_wr_data = obs_mem_wdata;
        r_wr_half = obs_half; r_wr_byte = obs_byte;
      end
      @(posedge clk);
      r_latency++;
      if (r_latency > 40) begin timed_out = 1'b1; break; end
    end
    n_cmp++;
    if (timed_out) begin
      n_bad++;
      $display("FAIL txn_timeout got no Resp_Valid within %0d edges want response", r_latency);
    end
    r_rdata = obs_resp_rdata; r_err = obs_resp_error;
    r_mem_addr_resp = obs_mem_addr; r_strobe_resp = obs_strobes;
    r_stable = 1'b1; r_ready_low = 1'b1;
    for (int h = 0; h < hold; h++) begin
      drv_rdata = ~drv_rdata;
      @(posedge clk);
      @(negedge clk);
      if (obs_resp_valid !== 1'b1 || obs_resp_rdata !== r_rdata || obs_resp_error !== r_err)
        r_stable = 1'b0;
      if (obs_req_ready !== 1'b0) r_ready_low = 1'b0;
    end
    drv_resp_ready = 1'b1;
    @(posedge clk);
    if (sel) exp_txn3 = exp_txn3 + 16'd1; else exp_txn1 = exp_txn1 + 16'd1;
    @(negedge clk);
    drv_resp_ready = 1'b0;
    r_after_valid = obs_resp_valid; r_after_ready = obs_req_ready; r_txn_after = obs_txn;
    $display("txn dut=%0d w=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d latency=%0d reads=%0d writes=%0d txn=%h",
             sel ? 3 : 1, w, sz, uns, addr, wdata, r_rdata, r_err, r_latency, r_reads, r_writes, r_txn_after);
  endtask

  task automatic test_reset();
    #1 rst1_n = 1'b0; rst3_n = 1'b0;
    @(posedge clk); #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      n_cmp++; if (obs_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready dut%0d got %b want 1", s, obs_req_ready); end
      n_cmp++; if (obs_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid dut%0d got %b want 0", s, obs_resp_valid); end
      n_cmp++; if (obs_resp_rdata !== 32'h0 || obs_resp_error !== 1'b0) begin n_bad++; $display("FAIL reset_resp dut%0d got %h/%b want 0/0", s, obs_resp_rdata, obs_resp_error); end
      n_cmp++; if (obs_strobes !== 4'b0) begin n_bad++; $display("FAIL reset_strobes dut%0d got %b want 0000", s, obs_strobes); end
      n_cmp++; if (obs_mem_addr !== 32'h0 || obs_mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_bus dut%0d got %h/%h want 0/0", s, obs_mem_addr, obs_mem_wdata); end
      n_cmp++; if (obs_txn !== 16'h0) begin n_bad++; $display("FAIL reset_txn dut%0d got %h want 0000", s, obs_txn); end
    end
    sel = 1'b0;
    @(posedge clk); #2;
    rst1_n = 1'b1; rst3_n = 1'b1;
  endtask

  task automatic test_word_load();
    sel = 1'b0;
    drv_rdata = 32'h8081_F0F7;
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    n_cmp++; if (r_accepted !== 1'b1) begin n_bad++; $display("FAIL wl_accept_first_edge got %b want 1", r_accepted); end
    n_cmp++; if (r_latency !== 2) begin n_bad++; $display("FAIL wl_latency got %0d want 2", r_latency); end
    n_cmp++; if (r_reads !== 1 || r_writes !== 0) begin n_bad++; $display("FAIL wl_strobes got rd=%0d wr=%0d want 1/0", r_reads, r_writes); end
    n_cmp++; if (r_rd_addr !== 32'h10 || r_rd_half !== 1'b0 || r_rd_byte !== 1'b0) begin n_bad++; $display("FAIL wl_mem_addr got %h h=%b b=%b want 10 0 0", r_rd_addr, r_rd_half, r_rd_byte); end
    n_cmp++; if (r_rdata !== 32'h8081_F0F7 || r_err !== 1'b0) begin n_bad++; $display("FAIL wl_rdata got %h err=%b want 8081f0f7 0", r_rdata, r_err); end
    n_cmp++; if (r_txn_after !== exp_txn1 || r_after_valid !== 1'b0 || r_after_ready !== 1'b1) begin n_bad++; $display("FAIL wl_complete got txn=%h v=%b r=%b want %h 0 1", r_txn_after, r_after_valid, r_after_ready, exp_txn1); end
  endtask

  task automatic test_half_byte_loads();
    sel = 1'b0;
    drv_rdata = 32'hFFFF_8081;
    run_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
    n_cmp++; if (r_rdata !== 32'hFFFF_8081 || r_rd_half !== 1'b1 || r_rd_byte !== 1'b0) begin n_bad++; $display("FAIL half_signed got %h h=%b b=%b want ffff8081 1 0", r_rdata, r_rd_half, r_rd_byte); end
    drv_rdata = 32'hFFFF_8081;
    run_txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
    n_cmp++; if (r_rdata !== 32'h0000_8081) begin n_bad++; $display("FAIL half_unsigned got %h want 00008081", r_rdata); end
    drv_rdata = 32'hFFFF_FF80;
    run_txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    n_cmp++; if (r_rdata !== 32'h0000_0080 || r_rd_byte !== 1'b1 || r_rd_half !== 1'b0) begin n_bad++; $display("FAIL byte_unsigned got %h b=%b h=%b want 00000080 1 0", r_rdata, r_rd_byte, r_rd_half); end
    drv_rdata = 32'hFFFF_FF80;
    run_txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    n_cmp++; if (r_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL byte_signed got %h want ffffff80", r_rdata); end
    n_cmp++; if (r_txn_after !== exp_txn1) begin n_bad++; $display("FAIL hb_txn got %h want %h", r_txn_after, exp_txn1); end
  endtask

  task automatic test_store_latency3();
    sel = 1'b1;
    drv_rdata = 32'h5555_5555;
    run_txn(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AB, 0);
    n_cmp++; if (r_latency !== 4) begin n_bad++; $display("FAIL st3_latency got %0d want 4", r_latency); end
    n_cmp++; if (r_writes !== 1 || r_wr_cycle !== 3 || r_reads !== 0) begin n_bad++; $display("FAIL st3_write_once got wr=%0d cyc=%0d rd=%0d want 1 3 0", r_writes, r_wr_cycle, r_reads); end
    n_cmp++; if (r_wr_byte !== 1'b1 || r_wr_half !== 1'b0) begin n_bad++; $display("FAIL st3_ctrl got b=%b h=%b want 1 0", r_wr_byte, r_wr_half); end
    n_cmp++; if (r_wr_addr !== 32'h21 || r_wr_data !== 32'hAB) begin n_bad++; $display("FAIL st3_mem_bus got %h/%h want 21/ab", r_wr_addr, r_wr_data); end
    n_cmp++; if (r_rdata !== 32'h0 || r_err !== 1'b0) begin n_bad++; $display("FAIL st3_resp got %h err=%b want 0 0", r_rdata, r_err); end
    drv_rdata = 32'h1234_5678;
    run_txn(1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0, 0);
    n_cmp++; if (r_latency !== 4 || r_reads !== 3) begin n_bad++; $display("FAIL ld3_timing got lat=%0d rd=%0d want 4 3", r_latency, r_reads); end
    n_cmp++; if (r_rdata !== 32'h1234_5678 || r_err !== 1'b0) begin n_bad++; $display("FAIL ld3_top_word got %h err=%b want 12345678 0", r_rdata, r_err); end
    n_cmp++; if (r_txn_after !== exp_txn3) begin n_bad++; $display("FAIL ld3_txn got %h want %h", r_txn_after, exp_txn3); end
  endtask

  task automatic test_errors();
    logic        t_w    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_size [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [31:0] t_addr [4] = '{32'h06, 32'h01, 32'h8000, 32'h00};
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv_rdata = 32'hDEAD_BEEF;
      run_txn(t_w[i], t_size[i], 1'b0, t_addr[i], 32'hFFFF_FFFF, 0);
      n_cmp++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin n_bad++; $display("FAIL err%0d_resp got err=%b rdata=%h want 1 0", i, r_err, r_rdata); end
      n_cmp++; if (r_latency !== 1) begin n_bad++; $display("FAIL err%0d_latency got %0d want 1", i, r_latency); end
      n_cmp++; if (r_reads !== 0 || r_writes !== 0 || r_strobe_resp !== 4'b0) begin n_bad++; $display("FAIL err%0d_strobes got rd=%0d wr=%0d resp=%b want 0 0 0000", i, r_reads, r_writes, r_strobe_resp); end
      n_cmp++; if (r_mem_addr_resp !== 32'h13) begin n_bad++; $display("FAIL err%0d_addr_hold got %h want 00000013", i, r_mem_addr_resp); end
      n_cmp++; if (r_txn_after !== exp_txn1) begin n_bad++; $display("FAIL err%0d_txn got %h want %h", i, r_txn_after, exp_txn1); end
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    @(negedge clk);
    force dut1.txn_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut1.txn_count_q;
    exp_txn1 = 16'hFFFF;
    @(negedge clk);
    n_cmp++; if (obs_txn !== 16'hFFFF) begin n_bad++; $display("FAIL bp_preset got %h want ffff", obs_txn); end
    drv_rdata = 32'hCAFE_F00D;
    run_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5);
    n_cmp++; if (r_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL bp_rdata got %h want cafef00d", r_rdata); end
    n_cmp++; if (r_stable !== 1'b1) begin n_bad++; $display("FAIL bp_stable got %b want 1", r_stable); end
    n_cmp++; if (r_ready_low !== 1'b1) begin n_bad++; $display("FAIL bp_req_ready_low got %b want 1", r_ready_low); end
    n_cmp++; if (r_txn_after !== 16'h0000 || r_txn_after !== exp_txn1) begin n_bad++; $display("FAIL bp_txn_wrap got %h want 0000", r_txn_after); end
  endtask

  task automatic test_reset_mid_store();
    int wr_before;
    sel = 1'b1;
    @(negedge clk);
    drv_write = 1'b1; drv_size = 2'b10; drv_uns = 1'b0;
    drv_addr = 32'h40; drv_wdata = 32'h1234_5678; drv_valid = 1'b1;
    wr_before = wr3_count;
    @(posedge clk);             // accept
    @(negedge clk);
    drv_valid = 1'b0;           // first ACCESS cycle
    @(posedge clk);             // second ACCESS cycle begins
    #2 rst3_n = 1'b0;
    #1;
    n_cmp++; if (obs_strobes !== 4'b0) begin n_bad++; $display("FAIL rst_mid_strobes got %b want 0000", obs_strobes); end
    n_cmp++; if (obs_req_ready !== 1'b1 || obs_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_handshake got ready=%b valid=%b want 1 0", obs_req_ready, obs_resp_valid); end
    n_cmp++; if (obs_mem_addr !== 32'h0 || obs_mem_wdata !== 32'h0 || obs_resp_rdata !== 32'h0 || obs_resp_error !== 1'b0) begin n_bad++; $display("FAIL rst_mid_outputs got %h %h %h %b want 0 0 0 0", obs_mem_addr, obs_mem_wdata, obs_resp_rdata, obs_resp_error); end
    n_cmp++; if (obs_txn !== 16'h0) begin n_bad++; $display("FAIL rst_mid_txn got %h want 0000", obs_txn); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (wr3_count !== wr_before) begin n_bad++; $display("FAIL rst_mid_no_write got %0d writes want 0", wr3_count - wr_before); end
    rst3_n = 1'b1;
    exp_txn3 = 16'h0;
    $display("txn dut=3 w=1 size=2 addr=00000040 aborted by reset");
    drv_rdata = 32'h0BAD_F00D;
    run_txn(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 0);
    n_cmp++; if (r_accepted !== 1'b1 || r_rdata !== 32'h0BAD_F00D || r_txn_after !== exp_txn3) begin n_bad++; $display("FAIL rst_recover got acc=%b rdata=%h txn=%h want 1 0badf00d %h", r_accepted, r_rdata, r_txn_after, exp_txn3); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_half_byte_loads();
    test_store_latency3();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion within 200000 time units want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_initiator.md
LOAD_STORE_INITIATOR -- requirements
Module: load_store_initiator

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 32768, giving the size of the data-memory address space in bytes.
REQ-002 The block SHALL have parameter LATENCY, default 1, range 1..15, giving the number of cycles the block holds the memory strobes per access.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, as follows.
REQ-004 Clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Req_Valid  in  1  CPU access request present.
REQ-007 Req_Ready  out  1  block accepts a request this cycle.
REQ-008 Req_Write  in  1  1 = store, 0 = load.
REQ-009 Req_Size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-010 Req_Unsigned  in  1  zero-extend load result; ignored on stores.
REQ-011 Req_Addr  in  32  byte address.
REQ-012 Req_WData  in  32  store data, right-aligned.
REQ-013 Resp_Valid  out  1  response present.
REQ-014 Resp_Ready  in  1  CPU accepts the response.
REQ-015 Resp_RData  out  32  load result.
REQ-016 Resp_Error  out  1  access rejected.
REQ-017 Mem_Address  out  32  data-memory address.
REQ-018 Mem_WriteData  out  32  data-memory write data.
REQ-019 Mem_MemWrite, Mem_MemRead, Mem_HalfControl, Mem_ByteControl  out  1 each  data-memory strobes.
REQ-020 Mem_ReadData  in  32  combinational read data, already sign-extended for half/byte.
REQ-021 Txn_Count  out  16  count of completed responses.

Function
REQ-022 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-023 Req_Ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where Req_Valid and Req_Ready are both 1.
REQ-024 On acceptance, the block SHALL latch Req_Write, Req_Size, Req_Unsigned, Req_Addr and Req_WData.
REQ-025 An accepted request SHALL be an error if any of the following holds: Req_Size = 11; half with Addr[0] = 1; word with Addr[1:0] ≠ 00; Addr ≥ MEM_BYTES.
REQ-026 On an error, the FSM SHALL go IDLE→RESP with Resp_Error = 1 and Resp_RData = 0, and SHALL assert no memory strobe.
REQ-027 On a legal request, the FSM SHALL go IDLE→ACCESS and load the wait counter with LATENCY-1.
REQ-028 In ACCESS, Mem_Address and Mem_WriteData SHALL carry the latched values.
REQ-029 In ACCESS, Mem_HalfControl SHALL be 1 for size 01, Mem_ByteControl SHALL be 1 for size 00, and both SHALL be 0 for word accesses.
REQ-030 For loads, Mem_MemRead SHALL be 1 for every ACCESS cycle.
REQ-031 For stores, Mem_MemWrite SHALL be 1 only in the final ACCESS cycle (counter = 0), so exactly one memory write occurs per store.
REQ-032 In ACCESS with counter ≠ 0, the block SHALL decrement the counter and remain in ACCESS.
REQ-033 In ACCESS with counter = 0, the FSM SHALL go to RESP at the next rising edge.
REQ-034 At that edge, a load SHALL register Mem_ReadData into Resp_RData; when Unsigned is set, bits above the access size SHALL be zeroed (half: [31:16], byte: [31:8]).
REQ-035 At that edge, a store SHALL set Resp_RData = 0; Resp_Error SHALL be 0 for legal accesses.
REQ-036 In RESP, Resp_Valid SHALL be 1 and Resp_RData/Resp_Error SHALL be held stable until Resp_Ready = 1.
REQ-037 At the edge where Resp_Ready = 1 in RESP, the FSM SHALL go to IDLE and Txn_Count SHALL increment (errors included), wrapping 0xFFFF→0x0000.
REQ-038 Latency SHALL be: accept edge → Resp_Valid after LATENCY+1 edges for legal accesses, after 1 edge for errors; there SHALL be no request/response overlap.
REQ-039 Outside ACCESS, all four memory strobes SHALL be 0 and Mem_Address/Mem_WriteData SHALL hold their last values.

Reset
REQ-040 When Reset_n = 0, the block SHALL immediately (asynchronously) enter IDLE and clear all outputs, latches and the counter to 0 (Req_Ready = 1 while in IDLE).
REQ-041 A reset asserted during ACCESS SHALL drop all strobes at once; a store whose final-cycle edge has not yet occurred SHALL NOT be written.
REQ-042 After Reset_n rises, the first request SHALL be acceptable at the first rising edge.

Verification
REQ-043 Word load, LATENCY = 1: memory word 0x10 = 0x8081_F0F7, Req addr 0x10, size 10 → Mem_MemRead high 1 cycle; Resp_RData = 0x8081F0F7; Resp_Error = 0.
REQ-044 Half load at addr 0x12 with Mem_ReadData = 0xFFFF8081: signed → 0xFFFF8081; unsigned → 0x00008081. Byte load at addr 0x13, unsigned → 0x00000080.
REQ-045 Byte store of 0xAB to addr 0x21 with LATENCY = 3 → Mem_MemWrite high exactly 1 cycle (the 3rd ACCESS cycle) with ByteControl = 1; Resp_Valid appears 4 edges after acceptance.
REQ-046 Errors: word load at 0x06, half store at 0x01, and load at 0x8000 (MEM_BYTES = 32768) → Resp_Error = 1, Resp_RData = 0, no strobes, and Txn_Count increments on each.
REQ-047 Backpressure: Resp_Ready held 0 for 5 cycles → Resp_Valid and data remain stable and Req_Ready remains 0; Txn_Count preset to 0xFFFF wraps to 0x0000 on completion.
REQ-048 Reset_n pulsed low during the second ACCESS cycle of a LATENCY = 3 store → no write occurs, all outputs are 0, and Req_Ready = 1.
